// File: rtl/accum_stage.sv
// ---------------------------------------------------------------------------
// accum_stage
// Streaming saturating accumulator that sits directly behind the adder stage.
// It sums up to LEN unsigned partial sums per vector and emits one result per
// vector. A vector closes on a beat flagged in_last or on the LEN-th beat.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream beat valid
//   in_ready   stage can accept a beat (registered, high only while accumulating)
//   in_data    unsigned partial sum from the adder
//   in_last    accepted beat closes the current vector early
//   clear      synchronous abort of the current vector and any pending result
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   accumulated result, clamped to the all-ones value on overflow
//   out_count  number of beats in this result (1..LEN)
//   out_sat    saturation occurred somewhere in this vector
// ---------------------------------------------------------------------------
module accum_stage #(
   parameter int IN_W  = 5,
   parameter int ACC_W = 12,
   parameter int LEN   = 8,
   localparam int CNT_W = $clog2(LEN + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   input  logic             clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat
);

   typedef enum logic [1:0] {
      INIT,
      ACCUM,
      HOLD
   } state_t;

   localparam logic [ACC_W-1:0] ACC_MAX  = '1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

   state_t           state;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] count;
   logic             sat;

   logic [ACC_W:0]   sum_wide;
   logic [ACC_W-1:0] acc_next;
   logic             sat_next;
   logic             accept;
   logic             closing;

   // Next accumulator value for the beat on the inputs. The sum is formed one
   // bit wider than the accumulator so an overflow is visible as a value above
   // ACC_MAX; in that case the result clamps and the sticky flag is raised.
   // A saturated accumulator already holds ACC_MAX, so it stays there.
   always_comb begin
      sum_wide = {1'b0, acc} + (ACC_W + 1)'(in_data);
      acc_next = sum_wide[ACC_W-1:0];
      sat_next = sat;
      if (sum_wide > {1'b0, ACC_MAX}) begin
         acc_next = ACC_MAX;
         sat_next = 1'b1;
      end
   end

   // in_ready is registered and only ever high in ACCUM, so the handshake
   // alone decides acceptance. A beat closes the vector either because the
   // producer flagged it or because it is the LEN-th beat; when both hold it
   // still closes exactly once.
   always_comb begin
      accept  = in_valid && in_ready;
      closing = in_last || (count == LAST_CNT);
   end

   // Single control process: reset, then clear, then the normal state flow.
   // The closing beat loads the output registers with the final totals and
   // wipes the working accumulator so the next vector starts from zero. HOLD
   // keeps the result frozen until the downstream handshake; that handshake
   // edge itself accepts nothing, which costs one bubble cycle per vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= INIT;
         acc       <= '0;
         count     <= '0;
         sat       <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_count <= '0;
         out_sat   <= 1'b0;
      end else if (clear) begin
         state     <= ACCUM;
         acc       <= '0;
         count     <= '0;
         sat       <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               state    <= ACCUM;
               in_ready <= 1'b1;
            end
            ACCUM: begin
               if (accept) begin
                  if (closing) begin
                     out_data  <= acc_next;
                     out_count <= count + CNT_W'(1);
                     out_sat   <= sat_next;
                     out_valid <= 1'b1;
                     in_ready  <= 1'b0;
                     state     <= HOLD;
                     acc       <= '0;
                     count     <= '0;
                     sat       <= 1'b0;
                  end else begin
                     acc   <= acc_next;
                     count <= count + CNT_W'(1);
                     sat   <= sat_next;
                  end
               end
            end
            HOLD: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ACCUM;
               end
            end
            default: begin
               state     <= INIT;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_accum_stage.sv
// ---------------------------------------------------------------------------
// tb_accum_stage
// Self-checking bench for accum_stage, built with a 6-bit accumulator so that
// saturation is reachable within one LEN=8 vector. Accepted beats feed a
// reference model that records the whole vector and, when it closes, pushes
// the expected result (clamped total, beat count, overflow flag) into a
// queue. A separate monitor pops that queue on every output handshake.
// ---------------------------------------------------------------------------
module tb_accum_stage;

   localparam int IN_W    = 5;
   localparam int ACC_W   = 6;
   localparam int LEN     = 8;
   localparam int CNT_W   = $clog2(LEN + 1);
   localparam int MAX_VAL = (1 << ACC_W) - 1;

   typedef struct {
      int data;
      int count;
      int sat;
   } result_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [IN_W-1:0]  in_data = '0;
   logic             in_last = 1'b0;
   logic             clear = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_data;
   logic [CNT_W-1:0] out_count;
   logic             out_sat;

   int      errors = 0;
   int      checks = 0;
   result_t exp_q[$];
   int      cur_beats[$];
   bit      random_ready = 1'b0;

   always #5 clk = ~clk;

   accum_stage #(
      .IN_W (IN_W),
      .ACC_W(ACC_W),
      .LEN  (LEN)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .in_last  (in_last),
      .clear    (clear),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_count(out_count),
      .out_sat  (out_sat)
   );

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference model: keep the beats of the open vector; when it closes, the
   // expected result is the plain sum clamped to the accumulator range.
   task automatic model_beat(input int data, input bit last);
      result_t r;
      int      total;
      cur_beats.push_back(data);
      if (last || cur_beats.size() == LEN) begin
         total = 0;
         foreach (cur_beats[i]) total += cur_beats[i];
         r.data  = (total > MAX_VAL) ? MAX_VAL : total;
         r.count = cur_beats.size();
         r.sat   = (total > MAX_VAL) ? 1 : 0;
         exp_q.push_back(r);
         cur_beats.delete();
      end
   endtask

   // Present one beat (called just after a rising edge) and hold it until an
   // edge where in_ready was high. Returns the number of edges waited.
   task automatic applyStimulus(input int data, input bit last, output int waited);
      bit rdy;
      rdy      = 1'b0;
      waited   = 0;
      in_valid = 1'b1;
      in_data  = IN_W'(data);
      in_last  = last;
      while (!rdy && waited < 50) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         waited++;
      end
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (rdy) begin
         model_beat(data, last);
      end else begin
         checks++;
         errors++;
         $display("[TB] FAIL beat_accept: in_ready low for %0d cycles, expected high within 50",
                  waited);
      end
   endtask

   // Wait (bounded) until every expected result has been delivered.
   task automatic drain();
      int n;
      n = 0;
      while ((out_valid !== 1'b0 || exp_q.size() != 0) && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("drain_pending", exp_q.size(), 0);
   endtask

   // Monitor: every output handshake must match the oldest expected result.
   always @(negedge clk) begin
      result_t r;
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_result: got out_data=%0d out_count=%0d, expected no result",
                     out_data, out_count);
         end else begin
            r = exp_q.pop_front();
            checkOutput("out_data", out_data, r.data);
            checkOutput("out_count", out_count, r.count);
            checkOutput("out_sat", out_sat, r.sat);
         end
      end
   end

   // Random downstream backpressure during the random phase.
   always @(posedge clk) begin
      if (random_ready) begin
         #1;
         out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: time limit reached, expected run to finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int w;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_out_count", out_count, 0);
      checkOutput("rst_out_sat", out_sat, 0);
      rst = 1'b0;
      checkOutput("init_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      checkOutput("ready_after_init", in_ready, 1);
      checkOutput("init_out_valid", out_valid, 0);
      checkOutput("init_out_data", out_data, 0);
      out_ready = 1'b1;

      // Full vector 1..8 back-to-back
      for (int i = 1; i <= 8; i++) applyStimulus(i, 1'b0, w);
      checkOutput("close_latency_valid", out_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
      checkOutput("ready_after_handshake", in_ready, 1);
      checkOutput("valid_after_handshake", out_valid, 0);

      // Early close, then a full vector unaffected by it
      applyStimulus(15, 1'b0, w);
      applyStimulus(15, 1'b0, w);
      applyStimulus(3, 1'b1, w);
      for (int i = 0; i < 8; i++) applyStimulus(4, 1'b0, w);

      // Saturation, then a short clean vector
      for (int i = 0; i < 8; i++) applyStimulus(31, 1'b0, w);
      applyStimulus(1, 1'b1, w);
      drain();

      // Backpressure: result frozen, no beats consumed while held
      out_ready = 1'b0;
      applyStimulus(2, 1'b1, w);
      in_valid = 1'b1;
      in_data  = IN_W'(17);
      in_last  = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checkOutput("bp_out_valid", out_valid, 1);
         checkOutput("bp_out_data", out_data, 2);
         checkOutput("bp_out_count", out_count, 1);
         checkOutput("bp_in_ready", in_ready, 0);
         @(posedge clk);
      end
      #1;
      out_ready = 1'b1;
      applyStimulus(7, 1'b1, w);
      checkOutput("bubble_wait", w, 2);
      drain();

      // Clear after three beats drops the partial vector and the clear-cycle beat
      for (int i = 0; i < 3; i++) applyStimulus(5, 1'b0, w);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_data  = IN_W'(9);
      in_last  = 1'b1;
      @(posedge clk);
      #1;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      cur_beats.delete();
      checkOutput("clear_in_ready", in_ready, 1);
      checkOutput("clear_out_valid", out_valid, 0);
      applyStimulus(2, 1'b1, w);
      drain();

      // Asynchronous reset while holding a result
      out_ready = 1'b0;
      applyStimulus(5, 1'b1, w);
      checkOutput("hold_before_rst", out_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_out_valid", out_valid, 0);
      checkOutput("async_rst_in_ready", in_ready, 0);
      checkOutput("async_rst_out_data", out_data, 0);
      exp_q.delete();
      cur_beats.delete();
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("ready_after_rst", in_ready, 1);

      // Randomized traffic with random backpressure and idle gaps
      random_ready = 1'b1;
      for (int n = 0; n < 150; n++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
         applyStimulus(int'($urandom_range(0, 31)), ($urandom_range(0, 4) == 0), w);
      end
      random_ready = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
